// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets, the STATUS bit positions and the TX state type.
package uart_pkg;

    localparam logic [31:0] DATA_OFS   = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_EMPTY   = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with a synchronous, active-high flush.
// Ports:
//   clk, reset          clock and synchronous flush
//   push, pushData      write request and data
//   pop, popData        read request and head-of-queue data (combinational)
//   full, empty, count  occupancy flags and entry count
// A push into a full FIFO is accepted only when a pop happens on the same edge.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign count  = wrPtr - rdPtr;
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign popData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage is not flushed; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (doPush && !reset) mem[wrPtr[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter sitting beside dmem on the data bus.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   MemWrite             core store strobe
//   DataAdr, WriteData   core data address and store data
//   ReadData             STATUS word when DataAdr addresses STATUS, else 0
//   Hit                  DataAdr addresses DATA or STATUS
//   tx                   registered serial output, idle high
// Stores to DATA queue a byte; stores to STATUS with bit3 set clear overflow.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        tx
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

    txState_t        state, stateNext;
    logic [CW-1:0]   cycleCnt, cycleNext;
    logic [2:0]      bitIdx, bitNext;
    logic [7:0]      shiftReg, shiftNext;
    logic            txReg, txNext;
    logic            overflow;

    logic            dataSel, statusSel;
    logic            fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [7:0]      fifoData;
    logic [CNTW-1:0] fifoCount;
    logic            bitDone;
    logic [31:0]     statusWord;
    logic [23:0]     unusedWriteData;

    assign dataSel   = (DataAdr == BASE_ADDR + DATA_OFS);
    assign statusSel = (DataAdr == BASE_ADDR + STATUS_OFS);
    assign Hit       = dataSel || statusSel;
    assign fifoPush  = MemWrite && dataSel;
    assign bitDone   = (cycleCnt == CW'(CLKS_PER_BIT - 1));
    assign tx        = txReg;
    assign unusedWriteData = WriteData[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) txFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifoPush),
        .pushData (WriteData[7:0]),
        .pop      (fifoPop),
        .popData  (fifoData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_comb begin
        statusWord = '0;
        statusWord[ST_BUSY]  = (state != IDLE);
        statusWord[ST_FULL]  = fifoFull;
        statusWord[ST_EMPTY] = fifoEmpty;
        statusWord[ST_OVF]   = overflow;
        statusWord[ST_CNT_LSB +: 4] = 4'(fifoCount);
    end

    assign ReadData = statusSel ? statusWord : '0;

    // tx is computed from the next state so the line changes on the same
    // edge as the state transition.
    always_comb begin
        stateNext = state;
        cycleNext = cycleCnt;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        txNext    = txReg;
        fifoPop   = 1'b0;

        if (state != IDLE) begin
            cycleNext = bitDone ? '0 : cycleCnt + 1'b1;
        end

        case (state)
            IDLE: begin
                txNext = 1'b1;
                if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    shiftNext = fifoData;
                    stateNext = START;
                    cycleNext = '0;
                    txNext    = 1'b0;
                end
            end
            START: begin
                if (bitDone) begin
                    stateNext = DATA;
                    bitNext   = '0;
                    txNext    = shiftReg[0];
                end
            end
            DATA: begin
                if (bitDone) begin
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                        txNext    = 1'b1;
                    end else begin
                        bitNext   = bitIdx + 3'd1;
                        shiftNext = {1'b0, shiftReg[7:1]};
                        txNext    = shiftReg[1];
                    end
                end
            end
            STOP: begin
                if (bitDone) begin
                    if (!fifoEmpty) begin
                        fifoPop   = 1'b1;
                        shiftNext = fifoData;
                        stateNext = START;
                        txNext    = 1'b0;
                    end else begin
                        stateNext = IDLE;
                        txNext    = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                txNext    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cycleCnt <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            txReg    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= stateNext;
            cycleCnt <= cycleNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
            txReg    <= txNext;
            // A pop on the same edge frees a slot, so only a true drop sets overflow.
            if (fifoPush && fifoFull && !fifoPop) begin
                overflow <= 1'b1;
            end else if (MemWrite && statusSel && WriteData[ST_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a frame-level model (byte queue plus
// position within the current 10-bit frame) predicts tx, Hit and ReadData on
// every cycle; directed sections pin the model with literal expectations.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          CPB   = 16;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = BASE + 32'd4;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Hit;
    logic        tx;

    int nAssert = 0;
    int nFail   = 0;

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    byte unsigned mQ[$];
    bit           mBusy = 0;
    bit           mOvf = 0;
    bit           mValid = 0;
    int           mPos = 0;
    byte unsigned mByte = 0;
    bit           popNow;
    byte unsigned head;

    always @(posedge clk) begin
        if (reset) begin
            mQ.delete();
            mBusy  = 0;
            mOvf   = 0;
            mPos   = 0;
            mValid = 1;
        end else if (mValid) begin
            popNow = (!mBusy || mPos == FRAME - 1) && (mQ.size() > 0);
            if (popNow) head = mQ.pop_front();
            if (MemWrite && DataAdr == BASE) begin
                if (mQ.size() < DEPTH) mQ.push_back(WriteData[7:0]);
                else mOvf = 1;
            end
            if (MemWrite && DataAdr == BASE + 32'd4 && WriteData[3]) mOvf = 0;
            if (popNow) begin
                mBusy = 1;
                mPos  = 0;
                mByte = head;
            end else if (mBusy) begin
                if (mPos == FRAME - 1) mBusy = 0;
                else mPos++;
            end
        end
    end

    function automatic logic expTx();
        if (!mBusy) return 1'b1;
        if (mPos < CPB) return 1'b0;
        if (mPos < 9 * CPB) return mByte[(mPos - CPB) / CPB];
        return 1'b1;
    endfunction

    function automatic logic [31:0] expStatus();
        logic [31:0] s;
        s = '0;
        s[0]   = mBusy;
        s[1]   = (mQ.size() == DEPTH);
        s[2]   = (mQ.size() == 0);
        s[3]   = mOvf;
        s[7:4] = 4'(mQ.size());
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (mValid) begin
            chk("tx", {31'd0, tx}, {31'd0, expTx()});
            chk("hit", {31'd0, Hit}, {31'd0, (DataAdr == BASE) || (DataAdr == BASE + 32'd4)});
            chk("readData", ReadData, (DataAdr == BASE + 32'd4) ? expStatus() : 32'd0);
        end
    end

    task automatic drive(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        reset     = rst;
        MemWrite  = we;
        DataAdr   = a;
        WriteData = d;
    endtask

    task automatic idle();
        drive(0, 0, BASE + 32'd4, 32'd0);
    endtask

    logic [7:0] frameByte;
    int         guard;
    int         r;

    initial begin
        // Reset for two edges.
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_status", ReadData, 32'h4);

        // Single byte 0xA5.
        frameByte = 8'hA5;
        drive(0, 1, BASE, 32'h0000_00A5);
        idle();                                   // push edge N has passed
        @(negedge clk);
        chk("single_pre_start", {31'd0, tx}, 32'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("single_start", {31'd0, tx}, 32'd0);
        for (int j = 1; j <= 9; j++) begin
            repeat (16) @(posedge clk);
            @(negedge clk);
            if (j <= 8) chk("single_bit", {31'd0, tx}, {31'd0, frameByte[j-1]});
            else        chk("single_stop", {31'd0, tx}, 32'd1);
        end
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("single_last_cycle", ReadData, 32'h5);
        @(posedge clk);
        @(negedge clk);
        chk("single_done", ReadData, 32'h4);

        // Back-to-back 0x55, 0x0F.
        drive(0, 1, BASE, 32'h55);
        drive(0, 1, BASE, 32'h0F);
        idle();
        for (int k = 0; k < 320; k++) begin
            @(negedge clk);
            chk("b2b_busy", {31'd0, ReadData[0]}, 32'd1);
            if (k == 159) chk("b2b_stop", {31'd0, tx}, 32'd1);
            if (k == 160) chk("b2b_restart", {31'd0, tx}, 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("b2b_done", ReadData, 32'h4);

        // Overflow: six pushes, first starts a frame, sixth is dropped.
        for (int i = 1; i <= 6; i++) drive(0, 1, BASE, 32'(i));
        drive(0, 1, BASE + 32'd4, 32'h8);
        @(negedge clk);
        chk("ovf_status", ReadData, 32'h4B);
        idle();
        @(negedge clk);
        chk("ovf_cleared", ReadData, 32'h43);

        // Push on the edge a STOP completes while full.
        guard = 0;
        while (!(mBusy && mPos == FRAME - 1) && guard < 400) begin
            idle();
            guard++;
        end
        chk("stop_wait_timeout", {31'd0, guard < 400}, 32'd1);
        drive(0, 1, BASE, 32'h77);
        idle();
        @(negedge clk);
        chk("full_push_pop", ReadData, 32'h43);

        // Reset during DATA bit 3.
        guard = 0;
        while (!(mBusy && mPos == CPB + 3 * CPB + 5) && guard < 400) begin
            idle();
            guard++;
        end
        chk("bit3_wait_timeout", {31'd0, guard < 400}, 32'd1);
        drive(1, 0, BASE + 32'd4, 32'd0);
        idle();
        @(negedge clk);
        chk("midreset_tx", {31'd0, tx}, 32'd1);
        chk("midreset_status", ReadData, 32'h4);
        repeat (200) idle();
        @(negedge clk);
        chk("midreset_quiet", {31'd0, tx}, 32'd1);

        // Address decode.
        drive(0, 1, BASE + 32'd8, 32'hAA);
        @(negedge clk);
        chk("decode_108_hit", {31'd0, Hit}, 32'd0);
        chk("decode_108_rd", ReadData, 32'd0);
        drive(0, 1, BASE - 32'd4, 32'hBB);
        @(negedge clk);
        chk("decode_0fc_hit", {31'd0, Hit}, 32'd0);
        idle();
        @(negedge clk);
        chk("decode_104_hit", {31'd0, Hit}, 32'd1);
        repeat (3) idle();
        @(negedge clk);
        chk("decode_tx_idle", {31'd0, tx}, 32'd1);
        chk("decode_status", ReadData, 32'h4);

        // Randomised traffic checked by the model every cycle.
        for (int c = 0; c < 6000; c++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 2999) == 0)
                drive(1, 0, BASE + 32'd4, 32'd0);
            else if (r < 3)
                drive(0, 1, BASE, $urandom);
            else if (r < 4)
                drive(0, 1, BASE + 32'd4, $urandom);
            else if (r < 5)
                drive(0, 1, BASE + 32'd8 + 32'(4 * $urandom_range(0, 4)), $urandom);
            else if (r < 8)
                drive(0, 0, BASE, 32'd0);
            else
                idle();
        end
        repeat (800) idle();
        @(negedge clk);
        chk("final_tx", {31'd0, tx}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the processor data-memory bus, alongside dmem.
- Decodes the core's MemWrite/DataAdr/WriteData outputs; stores to its data register queue bytes in a small FIFO.
- Bytes are serialised on `tx` as 8N1 frames.
- Status is readable through `ReadData` for software polling.

Parameters:
- BASE_ADDR, 32'h0000_0100: byte address of the DATA register; STATUS is at BASE_ADDR+4.
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be ≥2.
- FIFO_DEPTH, 4: byte entries. Power of two, 2..8.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- MemWrite  input  1  core store strobe
- DataAdr  input  32  core data address
- WriteData  input  32  core store data
- ReadData  output  32  STATUS value when DataAdr==BASE_ADDR+4, else 0 (combinational)
- Hit  output  1  1 when DataAdr is BASE_ADDR or BASE_ADDR+4 (combinational), for the top-level read mux and dmem write suppression
- tx  output  1  serial line, idle high, registered

Behaviour:
- Reset (synchronous, any time including mid-frame):
  - Next edge: tx=1, FIFO flushed, FSM=IDLE, bit/cycle counters=0, overflow=0.
- Push:
  - MemWrite && DataAdr==BASE_ADDR pushes WriteData[7:0] at that edge.
  - If the FIFO is full and no pop occurs that same edge, the byte is dropped and sticky overflow is set.
- Overflow clear: MemWrite && DataAdr==BASE_ADDR+4 && WriteData[3] clears overflow. Other bits are ignored.
- STATUS word:
  - bit0 busy (FSM!=IDLE)
  - bit1 full
  - bit2 empty
  - bit3 overflow
  - bits[7:4] occupancy count
  - bits[31:8]=0
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty at an edge, pop the head into the shift register and go to START with tx=0 from that edge.
  - START: hold for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bit index 0..7; after bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On completion, if the FIFO is non-empty, pop and go directly to START with no idle cycle; else go to IDLE.
- Frame timing and latency:
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - A push at edge N into an empty FIFO with FSM in IDLE makes tx low from edge N+1.
- Counters:
  - Cycle counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps on bit completion.
  - FIFO pointers are clog2(FIFO_DEPTH)+1 bits; full/empty come from pointer MSB comparison.
- Simultaneous push and pop:
  - On a full FIFO, both occur; occupancy is unchanged and no overflow.
  - On an empty FIFO, a push cannot be popped the same edge; the pop happens the following edge.
- Reads have no side effects. Writes to other addresses are ignored.

Decomposition:
- Package uart_pkg:
  - DATA_OFS=0, STATUS_OFS=4.
  - Status bit indices: ST_BUSY, ST_FULL, ST_EMPTY, ST_OVF, ST_CNT_LSB.
  - State enum: IDLE, START, DATA, STOP.
- Sub-module sync_fifo (parameterised WIDTH/DEPTH, push/pop/full/empty/count, synchronous reset flush).
- The FSM and shifter stay in uart_tx_mmio.

Test Plan:
- Single byte: reset 2 cycles, store 0x0000_00A5 to 0x100 → tx low next edge; bits 1,0,1,0,0,1,0,1 each 16 cycles; stop high; total 160 cycles; then STATUS reads 0x0000_0004.
- Back-to-back: store 0x55 then 0x0F on consecutive cycles → two frames with no idle gap between stop and second start; 320 cycles total; busy stays 1 throughout.
- Overflow: with the FSM busy, push 6 bytes while the FIFO holds 4 → 1st in START; FIFO full with 4; 6th dropped. STATUS = count 4, full=1, overflow=1, i.e. 0x0000_004B. Store 0x8 to 0x104 → overflow=0.
- Full push+pop: FIFO full, push at the exact edge the STOP completes → byte accepted, count stays 4, overflow stays 0.
- Reset mid-frame: assert reset during DATA bit 3 → next edge tx=1, STATUS=0x0000_0004; no residual frame afterwards.
- Decode: store to 0x108 and to 0x0FC → no push, tx idle, Hit=0. Read at 0x104 → Hit=1 and ReadData=STATUS.
